// File: rtl/cache_tag_nway.sv
// cache_tag_nway -- N-way set-associative tag store for the L1 I/D caches.
//
// Holds valid, dirty and tag state per way and set, plus a tree pseudo-LRU
// per set. Lookup, victim selection and write-back requests are all
// combinational; state updates happen on the rising clock edge.
//
// Optional feature macro: CACHE_TAG_PERF_EN (adds hit/miss perf counters).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               gates lookup outputs and lookup-driven updates
//   cached, sram_en     cacheable access / access valid this cycle
//   sram_wen            store access (marks line dirty on hit)
//   sram_tag, sram_index access tag and set
//   refresh             refill done, install sram_tag into victim way
//   op_way              way select for index-type CACHE ops
//   index_invalid, index_store_tag, hit_invalid,
//   index_wb_invalid, hit_wb_invalid   CACHE ops (one-hot or zero)
//   hit                 one-hot hit vector
//   victim              way for refill / write-back data select
//   miss, stallreq      cacheable miss
//   axi_raddr           refill address
//   write_back          selected line valid and dirty
//   axi_waddr           eviction address
//   perf_hit_cnt, perf_miss_cnt   (CACHE_TAG_PERF_EN only) saturating counters
module cache_tag_nway #(
    parameter int WAYS     = 4,
    parameter int SETS     = 64,
    parameter int OFFSET_W = 6,
    parameter int TAG_W    = 20,
    localparam int WAY_W   = $clog2(WAYS),
    localparam int IDX_W   = $clog2(SETS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              cached,
    input  logic              sram_en,
    input  logic              sram_wen,
    input  logic [TAG_W-1:0]  sram_tag,
    input  logic [IDX_W-1:0]  sram_index,
    input  logic              refresh,
    input  logic [WAY_W-1:0]  op_way,
    input  logic              index_invalid,
    input  logic              index_store_tag,
    input  logic              hit_invalid,
    input  logic              index_wb_invalid,
    input  logic              hit_wb_invalid,
    output logic [WAYS-1:0]   hit,
    output logic [WAY_W-1:0]  victim,
    output logic              miss,
    output logic              stallreq,
    output logic [31:0]       axi_raddr,
    output logic              write_back,
    output logic [31:0]       axi_waddr
`ifdef CACHE_TAG_PERF_EN
    ,
    output logic [31:0]       perf_hit_cnt,
    output logic [31:0]       perf_miss_cnt
`endif
);

    // Tree PLRU walk: node 0 is the root, children of node n are 2n+1 (bit 0,
    // lower ways) and 2n+2 (bit 1, upper ways). Leaves follow the last node.
    function automatic logic [WAY_W-1:0] plru_walk(input logic [WAYS-2:0] p);
        int  n;
        logic b;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int k = 0; k < WAYS - 1; k++) begin
                if (k == n) b = p[k];
            end
            n = 2 * n + 1 + (b ? 1 : 0);
        end
        return WAY_W'(n - (WAYS - 1));
    endfunction

    // Point every node on the path to `way` away from it.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] p,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] r;
        int   n;
        logic dir;
        r = p;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir = way[WAY_W-1-l];
            for (int k = 0; k < WAYS - 1; k++) begin
                if (k == n) r[k] = ~dir;
            end
            n = 2 * n + 1 + (dir ? 1 : 0);
        end
        return r;
    endfunction

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-2:0]  plru_q  [SETS];

    logic [WAYS-1:0]  cur_valid, cur_dirty;
    logic [TAG_W-1:0] cur_tag [WAYS];
    logic [WAYS-2:0]  cur_plru;
    logic [WAYS-1:0]  way_hit;
    logic             any_hit, access;
    logic [WAY_W-1:0] hit_way, inv_way;
    logic             vd_victim;

    logic [WAYS-1:0]  valid_d, dirty_d;
    logic [TAG_W-1:0] tag_d [WAYS];
    logic [WAYS-2:0]  plru_d;
    logic             upd_en;

    // Lookup and victim selection
    always_comb begin
        cur_valid = valid_q[sram_index];
        cur_dirty = dirty_q[sram_index];
        cur_tag   = tag_q[sram_index];
        cur_plru  = plru_q[sram_index];
        access    = sram_en & cached & ~flush;
        hit_way   = '0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = cur_valid[w] & (cur_tag[w] == sram_tag);
            if (way_hit[w]) hit_way = WAY_W'(w);
        end
        // Descending scan leaves the lowest-index invalid way.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!cur_valid[w]) inv_way = WAY_W'(w);
        end
        any_hit = |way_hit;
        hit     = way_hit & {WAYS{access}};
        miss    = access & ~any_hit;
        stallreq = miss;

        if (index_wb_invalid)
            victim = op_way;
        else if (hit_wb_invalid && any_hit)
            victim = hit_way;
        else if (!(&cur_valid))
            victim = inv_way;
        else
            victim = plru_walk(cur_plru);

        vd_victim = cur_valid[victim] & cur_dirty[victim];
        if (index_wb_invalid || hit_wb_invalid)
            write_back = ~flush & vd_victim & (index_wb_invalid | any_hit);
        else
            write_back = ~flush & miss & vd_victim;

        axi_raddr = {sram_tag, sram_index, {OFFSET_W{1'b0}}};
        axi_waddr = {cur_tag[victim], sram_index, {OFFSET_W{1'b0}}};
    end

    // Next state for the addressed set; one action per cycle by priority.
    always_comb begin
        valid_d = cur_valid;
        dirty_d = cur_dirty;
        tag_d   = cur_tag;
        plru_d  = cur_plru;
        upd_en  = 1'b0;
        if (refresh) begin
            tag_d[victim]   = sram_tag;
            valid_d[victim] = cached;
            dirty_d[victim] = 1'b0;
            plru_d          = plru_touch(cur_plru, victim);
            upd_en          = 1'b1;
        end else if (index_invalid || index_wb_invalid) begin
            valid_d[op_way] = 1'b0;
            dirty_d[op_way] = 1'b0;
            upd_en          = 1'b1;
        end else if (hit_invalid || hit_wb_invalid) begin
            if (any_hit) begin
                valid_d[hit_way] = 1'b0;
                dirty_d[hit_way] = 1'b0;
                upd_en           = 1'b1;
            end
        end else if (index_store_tag) begin
            tag_d[op_way]   = sram_tag;
            valid_d[op_way] = 1'b1;
            dirty_d[op_way] = 1'b0;
            upd_en          = 1'b1;
        end else if (|hit) begin
            plru_d = plru_touch(cur_plru, hit_way);
            if (sram_wen) dirty_d[hit_way] = 1'b1;
            upd_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
                for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
            end
        end else if (upd_en) begin
            valid_q[sram_index] <= valid_d;
            dirty_q[sram_index] <= dirty_d;
            tag_q[sram_index]   <= tag_d;
            plru_q[sram_index]  <= plru_d;
        end
    end

`ifdef CACHE_TAG_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        miss_prev_q, miss_prev_d;

    // A held miss counts once: only its rising edge increments.
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        miss_prev_d = miss;
        if (|hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
        if (miss && !miss_prev_q && miss_cnt_q != 32'hFFFF_FFFF)
            miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            miss_prev_q <= 1'b0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            miss_prev_q <= miss_prev_d;
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_tag_nway.sv
// Directed testbench for cache_tag_nway (WAYS=4, SETS=64, TAG_W=20).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 time unit later, well before the next edge.
module tb_cache_tag_nway;

    logic        clk = 1'b0;
    logic        rst, flush, cached, sram_en, sram_wen, refresh;
    logic [19:0] sram_tag;
    logic [5:0]  sram_index;
    logic [1:0]  op_way;
    logic        index_invalid, index_store_tag, hit_invalid;
    logic        index_wb_invalid, hit_wb_invalid;
    logic [3:0]  hit;
    logic [1:0]  victim;
    logic        miss, stallreq, write_back;
    logic [31:0] axi_raddr, axi_waddr;
`ifdef CACHE_TAG_PERF_EN
    logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_tag_nway dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .cached           (cached),
        .sram_en          (sram_en),
        .sram_wen         (sram_wen),
        .sram_tag         (sram_tag),
        .sram_index       (sram_index),
        .refresh          (refresh),
        .op_way           (op_way),
        .index_invalid    (index_invalid),
        .index_store_tag  (index_store_tag),
        .hit_invalid      (hit_invalid),
        .index_wb_invalid (index_wb_invalid),
        .hit_wb_invalid   (hit_wb_invalid),
        .hit              (hit),
        .victim           (victim),
        .miss             (miss),
        .stallreq         (stallreq),
        .axi_raddr        (axi_raddr),
        .write_back       (write_back),
        .axi_waddr        (axi_waddr)
`ifdef CACHE_TAG_PERF_EN
        ,
        .perf_hit_cnt     (perf_hit_cnt),
        .perf_miss_cnt    (perf_miss_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; cached = 1; sram_en = 0; sram_wen = 0; refresh = 0;
        sram_tag = '0; sram_index = 6'd5; op_way = '0;
        index_invalid = 0; index_store_tag = 0; hit_invalid = 0;
        index_wb_invalid = 0; hit_wb_invalid = 0;
    endtask

    task automatic access(input logic [19:0] t, input logic wen);
        idle();
        sram_en = 1; sram_tag = t; sram_wen = wen;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;

        // Reset state
        access(20'h100, 0); #1;
        chk("rst_hit", 32'(hit), 32'h0);
        chk("rst_miss", 32'(miss), 32'h1);
        chk("rst_stall", 32'(stallreq), 32'h1);
        chk("rst_wb", 32'(write_back), 32'h0);
        chk("rst_victim", 32'(victim), 32'h0);
        chk("rst_raddr", axi_raddr, 32'h0010_0140);
        tick();

        // Cold fill: invalid ways chosen lowest first
        for (int i = 0; i < 4; i++) begin
            access(20'h100 + 20'(i), 0); #1;
            chk("fill_miss", 32'(miss), 32'h1);
            chk("fill_victim", 32'(victim), 32'(i));
            chk("fill_wb", 32'(write_back), 32'h0);
            refresh = 1;
            tick();
        end
        access(20'h102, 0); #1;
        chk("fill_hit", 32'(hit), 32'h4);
        chk("fill_hit_miss", 32'(miss), 32'h0);
        tick();

        // PLRU: touching 2 then 0 then 1 leaves root->upper half, node2->way3
        access(20'h102, 0); #1; chk("plru_h2", 32'(hit), 32'h4); tick();
        access(20'h100, 0); #1; chk("plru_h0", 32'(hit), 32'h1); tick();
        access(20'h101, 0); #1; chk("plru_h1", 32'(hit), 32'h2); tick();
        access(20'h104, 0); #1;
        chk("plru_miss", 32'(miss), 32'h1);
        chk("plru_victim", 32'(victim), 32'h3);
        chk("plru_wb", 32'(write_back), 32'h0);
        chk("plru_waddr", axi_waddr, 32'h0010_3140);
        tick();

        // Dirty eviction
        access(20'h103, 1); #1; chk("st_hit3", 32'(hit), 32'h8); tick();
        access(20'h102, 0); tick();
        access(20'h100, 0); tick();
        access(20'h101, 0); tick();
        access(20'h104, 0); #1;
        chk("dirty_victim", 32'(victim), 32'h3);
        chk("dirty_wb", 32'(write_back), 32'h1);
        chk("dirty_waddr", axi_waddr, 32'h0010_3140);
        refresh = 1;
        tick();
        idle(); index_wb_invalid = 1; op_way = 2'd3; #1;
        chk("newline_victim", 32'(victim), 32'h3);
        chk("newline_clean_wb", 32'(write_back), 32'h0);
        chk("newline_waddr", axi_waddr, 32'h0010_4140);
        tick();
        access(20'h104, 0); #1;
        chk("inv3_miss", 32'(miss), 32'h1);
        chk("inv3_victim", 32'(victim), 32'h3);
        refresh = 1;
        tick();

        // Flush gating: store-hit under flush must not touch PLRU or dirty
        access(20'h100, 1); flush = 1; #1;
        chk("flush_hit", 32'(hit), 32'h0);
        chk("flush_miss", 32'(miss), 32'h0);
        chk("flush_wb", 32'(write_back), 32'h0);
        tick();
        access(20'h105, 0); #1;
        chk("postflush_miss", 32'(miss), 32'h1);
        chk("postflush_victim", 32'(victim), 32'h0);
        chk("postflush_wb", 32'(write_back), 32'h0);
        tick();

        // CACHE ops
        access(20'h102, 1); #1; chk("st_hit2", 32'(hit), 32'h4); tick();
        idle(); index_wb_invalid = 1; op_way = 2'd2; #1;
        chk("iwbi_victim", 32'(victim), 32'h2);
        chk("iwbi_wb", 32'(write_back), 32'h1);
        chk("iwbi_waddr", axi_waddr, 32'h0010_2140);
        tick();
        access(20'h102, 0); #1; chk("iwbi_after_miss", 32'(miss), 32'h1); tick();
        access(20'h1FF, 0); hit_invalid = 1; #1;
        chk("hi_nohit_miss", 32'(miss), 32'h1);
        chk("hi_nohit_wb", 32'(write_back), 32'h0);
        tick();
        access(20'h100, 0); #1; chk("hi_keep0", 32'(hit), 32'h1); tick();
        access(20'h101, 0); #1; chk("hi_keep1", 32'(hit), 32'h2); tick();
        access(20'h104, 0); #1; chk("hi_keep3", 32'(hit), 32'h8); tick();
        access(20'h101, 1); tick();
        access(20'h101, 0); hit_wb_invalid = 1; #1;
        chk("hwbi_victim", 32'(victim), 32'h1);
        chk("hwbi_wb", 32'(write_back), 32'h1);
        chk("hwbi_waddr", axi_waddr, 32'h0010_1140);
        tick();
        access(20'h101, 0); #1; chk("hwbi_after_miss", 32'(miss), 32'h1); tick();

        // Uncached access: no hit/miss, store must not dirty the line
        access(20'h100, 1); cached = 0; #1;
        chk("unc_hit", 32'(hit), 32'h0);
        chk("unc_miss", 32'(miss), 32'h0);
        tick();
        idle(); index_wb_invalid = 1; op_way = 2'd0; #1;
        chk("unc_clean_wb", 32'(write_back), 32'h0);
        tick();

        // Reset mid-operation
        access(20'h1FF, 0); rst = 1; #1;
        chk("midrst_miss", 32'(miss), 32'h1);
        tick();
        rst = 0;
        access(20'h104, 0); #1;
        chk("postrst_miss", 32'(miss), 32'h1);
        chk("postrst_hit", 32'(hit), 32'h0);
        chk("postrst_wb", 32'(write_back), 32'h0);
        chk("postrst_victim", 32'(victim), 32'h0);
`ifdef CACHE_TAG_PERF_EN
        chk("postrst_perf_hit", perf_hit_cnt, 32'h0);
        chk("postrst_perf_miss", perf_miss_cnt, 32'h0);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
